// File: rtl/ldst_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldst_queue_pkg
// Description : Shared types and default widths for the load/store queue.
// Revision    : 1.0 - initial release
// ============================================================================
package ldst_queue_pkg;

  // Default geometry of the queue and its payload fields
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_AW    = 32;
  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_CW    = 4;
  localparam int unsigned DEF_ZW    = 4;

  // Lifecycle of a queue entry
  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,  // slot unused
    ST_WAIT   = 2'd1,  // allocated, not yet sent to memory
    ST_ISSUED = 2'd2,  // request accepted by memory, awaiting response
    ST_DONE   = 2'd3   // completed (or forwarded), waiting to retire
  } entry_state_e;

endpackage : ldst_queue_pkg
`default_nettype wire

// File: rtl/ldst_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : ldst_fwd_match
// Description : Finds the youngest in-queue store whose word address matches
//               an incoming load. Age is measured from the head pointer, so
//               the last match found walking head..head+DEPTH-1 is youngest.
// Revision    : 1.0 - initial release
// ============================================================================
module ldst_fwd_match #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDW   = 4,
  parameter int unsigned WAW   = 30
) (
  input  logic [DEPTH-1:0] cand_i,            // entry is a live store
  input  logic [WAW-1:0]   waddr_i [DEPTH],   // word address per entry
  input  logic [WAW-1:0]   key_i,             // word address of the load
  input  logic [IDW-1:0]   head_i,            // oldest entry
  output logic             hit_o,
  output logic [IDW-1:0]   idx_o
);

  // Walk entries oldest to youngest; later matches override earlier ones
  always_comb begin
    logic [IDW-1:0] idx;
    hit_o = 1'b0;
    idx_o = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + IDW'(k);
      if (cand_i[idx] && (waddr_i[idx] == key_i)) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule : ldst_fwd_match
`default_nettype wire

// File: rtl/ldst_queue_fwd.sv
`default_nettype none
// ============================================================================
// Module      : ldst_queue_fwd
// Description : In-order load/store queue with store-to-load forwarding.
//               Entries issue to memory in order, complete out of order by
//               queue ID and retire in order. Loads hitting an older store
//               take its data and skip the memory request entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module ldst_queue_fwd
  import ldst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned CW    = DEF_CW,
  parameter int unsigned ZW    = DEF_ZW,
  localparam int unsigned IDW  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  // core enqueue
  input  logic           enq_valid_i,
  input  logic           enq_rw_i,
  input  logic [AW-1:0]  enq_addr_i,
  input  logic [DW-1:0]  enq_data_i,
  input  logic [CW-1:0]  enq_cntrl_i,
  input  logic [ZW-1:0]  enq_z_i,
  output logic           enq_ready_o,
  // memory request
  output logic           mem_valid_o,
  output logic           mem_rw_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic [DW-1:0]  mem_data_o,
  output logic [IDW-1:0] mem_id_o,
  input  logic           mem_stall_i,
  // memory response
  input  logic           mem_resp_valid_i,
  input  logic [IDW-1:0] mem_resp_id_i,
  input  logic [DW-1:0]  mem_resp_data_i,
  // retire
  output logic           ret_valid_o,
  output logic           ret_rw_o,
  output logic [AW-1:0]  ret_addr_o,
  output logic [DW-1:0]  ret_data_o,
  output logic [CW-1:0]  ret_cntrl_o,
  output logic [ZW-1:0]  ret_z_o,
  output logic           ret_fwd_o,
  // status
  output logic           empty_o,
  output logic           full_o,
  output logic [IDW:0]   count_o
);

  localparam int unsigned    WAW     = AW - 2;
  localparam logic [IDW-1:0] PTR_ONE = IDW'(1);
  localparam logic [IDW:0]   CNT_MAX = (IDW+1)'(DEPTH);

  // Entry storage
  entry_state_e  state_q [DEPTH];
  logic          rw_q    [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [CW-1:0] cntrl_q [DEPTH];
  logic [ZW-1:0] z_q     [DEPTH];
  logic          fwd_q   [DEPTH];

  // Pointers and occupancy
  logic [IDW-1:0] head_q, tail_q, iss_q;
  logic [IDW:0]   count_q, count_d;
  logic           empty_q, full_q;

  // Retire output registers
  logic           ret_valid_q, ret_rw_q, ret_fwd_q;
  logic [AW-1:0]  ret_addr_q;
  logic [DW-1:0]  ret_data_q;
  logic [CW-1:0]  ret_cntrl_q;
  logic [ZW-1:0]  ret_z_q;

  // Control decodes
  logic           w_enq_acc, w_issue, w_skip, w_resp, w_ret;
  logic           w_hit, w_ld_fwd;
  logic [IDW-1:0] w_hit_idx;
  logic [DEPTH-1:0] w_cand;
  logic [WAW-1:0]   w_waddr [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign w_cand[g]  = rw_q[g] && (state_q[g] != ST_FREE);
    assign w_waddr[g] = addr_q[g][AW-1:2];
  end

  ldst_fwd_match #(
    .DEPTH (DEPTH),
    .IDW   (IDW),
    .WAW   (WAW)
  ) u_match (
    .cand_i  (w_cand),
    .waddr_i (w_waddr),
    .key_i   (enq_addr_i[AW-1:2]),
    .head_i  (head_q),
    .hit_o   (w_hit),
    .idx_o   (w_hit_idx)
  );

  assign w_enq_acc   = enq_valid_i && !full_q;
  assign w_ld_fwd    = !enq_rw_i && w_hit;
  assign mem_valid_o = (state_q[iss_q] == ST_WAIT);
  assign w_issue     = mem_valid_o && !mem_stall_i;
  // A full queue also has iss==tail; the guard keeps iss from lapping head.
  assign w_skip      = (state_q[iss_q] == ST_DONE) && (iss_q != tail_q);
  assign w_resp      = mem_resp_valid_i && (state_q[mem_resp_id_i] == ST_ISSUED);
  assign w_ret       = (state_q[head_q] == ST_DONE);

  assign mem_rw_o    = rw_q[iss_q];
  assign mem_addr_o  = addr_q[iss_q];
  assign mem_data_o  = data_q[iss_q];
  assign mem_id_o    = iss_q;

  // Occupancy after this edge's enqueue and retire
  always_comb begin
    count_d = count_q + (IDW+1)'(w_enq_acc) - (IDW+1)'(w_ret);
  end

  // Entry states, pointers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
      head_q  <= '0;
      tail_q  <= '0;
      iss_q   <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      // The four updates below always target different entries: tail is
      // FREE, iss is WAIT, the responder is ISSUED and head is DONE.
      if (w_enq_acc) state_q[tail_q] <= w_ld_fwd ? ST_DONE : ST_WAIT;
      if (w_issue)   state_q[iss_q] <= ST_ISSUED;
      if (w_resp)    state_q[mem_resp_id_i] <= ST_DONE;
      if (w_ret)     state_q[head_q] <= ST_FREE;
      if (w_enq_acc)           tail_q <= tail_q + PTR_ONE;
      if (w_issue || w_skip)   iss_q  <= iss_q + PTR_ONE;
      if (w_ret)               head_q <= head_q + PTR_ONE;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_MAX);
    end
  end

  // Entry payload; only meaningful while the entry is not FREE
  always_ff @(posedge clk) begin
    if (w_enq_acc) begin
      rw_q[tail_q]    <= enq_rw_i;
      addr_q[tail_q]  <= enq_addr_i;
      data_q[tail_q]  <= w_ld_fwd ? data_q[w_hit_idx] : enq_data_i;
      cntrl_q[tail_q] <= enq_cntrl_i;
      z_q[tail_q]     <= enq_z_i;
      fwd_q[tail_q]   <= w_ld_fwd;
    end
    if (w_resp && !rw_q[mem_resp_id_i]) begin
      data_q[mem_resp_id_i] <= mem_resp_data_i;
    end
  end

  // Retire register: pulse valid, hold the fields of the last retired entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_valid_q <= 1'b0;
      ret_rw_q    <= 1'b0;
      ret_addr_q  <= '0;
      ret_data_q  <= '0;
      ret_cntrl_q <= '0;
      ret_z_q     <= '0;
      ret_fwd_q   <= 1'b0;
    end else begin
      ret_valid_q <= w_ret;
      if (w_ret) begin
        ret_rw_q    <= rw_q[head_q];
        ret_addr_q  <= addr_q[head_q];
        ret_data_q  <= data_q[head_q];
        ret_cntrl_q <= cntrl_q[head_q];
        ret_z_q     <= z_q[head_q];
        ret_fwd_q   <= fwd_q[head_q];
      end
    end
  end

  assign ret_valid_o = ret_valid_q;
  assign ret_rw_o    = ret_rw_q;
  assign ret_addr_o  = ret_addr_q;
  assign ret_data_o  = ret_data_q;
  assign ret_cntrl_o = ret_cntrl_q;
  assign ret_z_o     = ret_z_q;
  assign ret_fwd_o   = ret_fwd_q;

  assign enq_ready_o = !full_q;
  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign count_o     = count_q;

endmodule : ldst_queue_fwd
`default_nettype wire

// File: tb/tb_ldst_queue_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_ldst_queue_fwd
// Description : Directed bench for ldst_queue_fwd with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ldst_queue_fwd;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int ZW    = 4;
  localparam int IDW   = 4;

  logic           clk, rst;
  logic           enq_valid, enq_rw, enq_ready;
  logic [AW-1:0]  enq_addr;
  logic [DW-1:0]  enq_data;
  logic [CW-1:0]  enq_cntrl;
  logic [ZW-1:0]  enq_z;
  logic           mem_valid, mem_rw, mem_stall;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_data;
  logic [IDW-1:0] mem_id;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [DW-1:0]  resp_data;
  logic           ret_valid, ret_rw, ret_fwd;
  logic [AW-1:0]  ret_addr;
  logic [DW-1:0]  ret_data;
  logic [CW-1:0]  ret_cntrl;
  logic [ZW-1:0]  ret_z;
  logic           empty, full;
  logic [IDW:0]   count;

  int n_checks = 0;
  int n_err    = 0;

  ldst_queue_fwd #(
    .DEPTH (DEPTH), .AW (AW), .DW (DW), .CW (CW), .ZW (ZW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enq_valid_i      (enq_valid),
    .enq_rw_i         (enq_rw),
    .enq_addr_i       (enq_addr),
    .enq_data_i       (enq_data),
    .enq_cntrl_i      (enq_cntrl),
    .enq_z_i          (enq_z),
    .enq_ready_o      (enq_ready),
    .mem_valid_o      (mem_valid),
    .mem_rw_o         (mem_rw),
    .mem_addr_o       (mem_addr),
    .mem_data_o       (mem_data),
    .mem_id_o         (mem_id),
    .mem_stall_i      (mem_stall),
    .mem_resp_valid_i (resp_valid),
    .mem_resp_id_i    (resp_id),
    .mem_resp_data_i  (resp_data),
    .ret_valid_o      (ret_valid),
    .ret_rw_o         (ret_rw),
    .ret_addr_o       (ret_addr),
    .ret_data_o       (ret_data),
    .ret_cntrl_o      (ret_cntrl),
    .ret_z_o          (ret_z),
    .ret_fwd_o        (ret_fwd),
    .empty_o          (empty),
    .full_o           (full),
    .count_o          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid  = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    mem_stall = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic enq(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    enq_valid = 1'b1;
    enq_rw    = rw;
    enq_addr  = a;
    enq_data  = d;
  endtask

  task automatic resp(input logic [IDW-1:0] id, input logic [DW-1:0] d);
    resp_valid = 1'b1;
    resp_id    = id;
    resp_data  = d;
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0;
    enq_valid = 0; enq_rw = 0; enq_addr = '0; enq_data = '0; enq_cntrl = '0; enq_z = '0;
    resp_valid = 0; resp_id = '0; resp_data = '0;

    // ---------------- reset state
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", enq_ready, 1);
    chk("rst_memv", mem_valid, 0);
    chk("rst_retv", ret_valid, 0);
    chk("rst_retdata", ret_data, 0);

    // ---------------- single load through memory
    enq(0, 32'h8, 32'h0); enq_cntrl = 4'h3; enq_z = 4'h5;
    tick();
    idle();
    chk("t1_memv", mem_valid, 1);
    chk("t1_memid", mem_id, 0);
    chk("t1_memaddr", mem_addr, 32'h8);
    chk("t1_memrw", mem_rw, 0);
    chk("t1_count", count, 1);
    chk("t1_empty", empty, 0);
    tick();
    chk("t1_memv_after_issue", mem_valid, 0);
    tick();
    resp(0, 32'h1234);
    tick();
    idle();
    chk("t1_no_early_ret", ret_valid, 0);
    tick();
    chk("t1_retv", ret_valid, 1);
    chk("t1_retdata", ret_data, 32'h1234);
    chk("t1_retfwd", ret_fwd, 0);
    chk("t1_retz", ret_z, 4'h5);
    chk("t1_retcntrl", ret_cntrl, 4'h3);
    chk("t1_retaddr", ret_addr, 32'h8);
    chk("t1_empty_back", empty, 1);
    tick();
    chk("t1_retv_pulse", ret_valid, 0);
    chk("t1_retdata_hold", ret_data, 32'h1234);

    // ---------------- store then forwarded load
    do_reset();
    enq_cntrl = 4'h0; enq_z = 4'h0;
    enq(1, 32'h10, 32'hAA);
    tick();
    chk("t2_st_memv", mem_valid, 1);
    chk("t2_st_memid", mem_id, 0);
    chk("t2_st_memrw", mem_rw, 1);
    chk("t2_st_memdata", mem_data, 32'hAA);
    enq(0, 32'h12, 32'h0);
    tick();
    idle();
    chk("t2_ld_no_req", mem_valid, 0);
    tick();
    chk("t2_ld_no_req2", mem_valid, 0);
    resp(0, 32'hDEAD);
    tick();
    idle();
    chk("t2_st_noret", ret_valid, 0);
    tick();
    chk("t2_st_retv", ret_valid, 1);
    chk("t2_st_retrw", ret_rw, 1);
    chk("t2_st_retdata", ret_data, 32'hAA);
    tick();
    chk("t2_ld_retv", ret_valid, 1);
    chk("t2_ld_retrw", ret_rw, 0);
    chk("t2_ld_retdata", ret_data, 32'hAA);
    chk("t2_ld_retfwd", ret_fwd, 1);
    chk("t2_ld_retaddr", ret_addr, 32'h12);
    chk("t2_empty", empty, 1);

    // ---------------- out-of-order completion, in-order retire
    do_reset();
    enq(0, 32'h100, 0);
    tick();
    chk("t3_id0", mem_id, 0);
    enq(0, 32'h104, 0);
    tick();
    chk("t3_id1", mem_id, 1);
    enq(0, 32'h108, 0);
    tick();
    chk("t3_id2", mem_id, 2);
    idle();
    tick();
    chk("t3_all_issued", mem_valid, 0);
    resp(2, 32'hC2);
    tick();
    resp(0, 32'hC0);
    tick();
    chk("t3_no_ret", ret_valid, 0);
    resp(1, 32'hC1);
    tick();
    idle();
    chk("t3_r0v", ret_valid, 1);
    chk("t3_r0d", ret_data, 32'hC0);
    chk("t3_r0a", ret_addr, 32'h100);
    tick();
    chk("t3_r1v", ret_valid, 1);
    chk("t3_r1d", ret_data, 32'hC1);
    tick();
    chk("t3_r2v", ret_valid, 1);
    chk("t3_r2d", ret_data, 32'hC2);
    tick();
    chk("t3_idle", ret_valid, 0);
    chk("t3_empty", empty, 1);
    // response to a FREE entry is ignored
    resp(0, 32'hBAD);
    tick();
    idle();
    tick();
    chk("t3_stray_ret", ret_valid, 0);
    chk("t3_stray_count", count, 0);

    // ---------------- fill to full, drop 17th, drain and wrap
    do_reset();
    mem_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      enq(0, 32'h200 + 4*i, 0);
      tick();
    end
    chk("t4_full", full, 1);
    chk("t4_ready", enq_ready, 0);
    chk("t4_count", count, 16);
    chk("t4_stall_memv", mem_valid, 1);
    chk("t4_stall_id", mem_id, 0);
    enq(0, 32'h300, 0);
    tick();
    idle();
    chk("t4_drop_count", count, 16);
    mem_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("t4_issued_all", mem_valid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      resp(i[IDW-1:0], 32'h5000 + i);
      if (i == 1) enq(0, 32'h400, 0);
      tick();
      enq_valid = 1'b0;
      chk("t4_retv", ret_valid, (i != 0));
      if (i != 0) begin
        chk("t4_retd", ret_data, 32'h5000 + i - 1);
        chk("t4_reta", ret_addr, 32'h200 + 4*(i-1));
      end
      chk("t4_cnt", count, 16 - i);
    end
    idle();
    tick();
    chk("t4_last_retv", ret_valid, 1);
    chk("t4_last_retd", ret_data, 32'h500F);
    chk("t4_last_reta", ret_addr, 32'h23C);
    chk("t4_drained", empty, 1);
    tick();
    chk("t4_quiet", ret_valid, 0);
    enq(0, 32'h500, 0);
    tick();
    idle();
    chk("t4_wrap_memv", mem_valid, 1);
    chk("t4_wrap_id", mem_id, 0);
    chk("t4_wrap_addr", mem_addr, 32'h500);

    // ---------------- youngest store wins; retire-edge forwarding
    do_reset();
    mem_stall = 1'b1;
    enq(1, 32'h20, 32'h1);
    tick();
    enq(1, 32'h20, 32'h2);
    tick();
    enq(0, 32'h20, 32'h0);
    tick();
    idle();
    mem_stall = 1'b0;
    tick();                       // issue store 0
    tick();                       // issue store 1
    resp(0, 32'h0);
    tick();
    resp(1, 32'h0);
    tick();
    idle();
    chk("t5_s0_retd", ret_data, 32'h1);
    enq(0, 32'h20, 32'h0);        // enqueued on the edge store 1 retires
    tick();
    idle();
    chk("t5_s1_retv", ret_valid, 1);
    chk("t5_s1_retd", ret_data, 32'h2);
    tick();
    chk("t5_ld_retd", ret_data, 32'h2);
    chk("t5_ld_fwd", ret_fwd, 1);
    chk("t5_cnt1", count, 1);
    enq(0, 32'h44, 32'h0);        // enqueue while the last entry retires
    tick();
    idle();
    chk("t5_ld2_retd", ret_data, 32'h2);
    chk("t5_ld2_fwd", ret_fwd, 1);
    chk("t5_cnt_hold", count, 1);
    chk("t5_not_empty", empty, 0);
    chk("t5_miss_memv", mem_valid, 1);
    chk("t5_miss_addr", mem_addr, 32'h44);

    // ---------------- reset with entries in flight
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq(0, 32'h600 + 4*i, 0);
      tick();
    end
    idle();
    tick();
    chk("t6_inflight", count, 5);
    rst = 1'b1;
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_empty", empty, 1);
    chk("t6_async_memv", mem_valid, 0);
    tick();
    rst = 1'b0;
    resp(0, 32'h77);
    tick();
    idle();
    tick();
    chk("t6_no_ret", ret_valid, 0);
    tick();
    chk("t6_no_ret2", ret_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule : tb_ldst_queue_fwd
`default_nettype wire

// File: doc/ldst_queue_fwd.md
# ldst_queue_fwd

In-order load/store queue between the core's memory stage and the data cache, parametrised in depth and widths. Entries are issued to memory in program order under a valid/stall handshake, complete out of order by queue ID, and retire to the core strictly in order. Loads whose word address matches an older in-queue store take that store's data and never go to memory. Full and empty are exact, and the core is backpressured when the queue is full.

## Interface
- DEPTH, 16, entry count; power of 2, ≥2
- AW, 32, address width
- DW, 32, data width
- CW, 4, control-tag width carried to retire
- ZW, 4, destination-register tag width
- IDW, $clog2(DEPTH), queue ID width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- enq_valid  in  1  core presents a ld/st
- enq_rw  in  1  1=store, 0=load
- enq_addr  in  AW  byte address
- enq_data  in  DW  store data; ignored for loads
- enq_cntrl  in  CW  control tag
- enq_z  in  ZW  destination tag
- enq_ready  out  1  equals !full
- mem_valid  out  1  request valid
- mem_rw, mem_addr, mem_data, mem_id  out  1/AW/DW/IDW  request fields
- mem_stall  in  1  memory cannot accept this cycle
- mem_resp_valid  in  1  completion valid
- mem_resp_id  in  IDW  ID being completed
- mem_resp_data  in  DW  load data
- ret_valid  out  1  one-cycle retire pulse
- ret_rw, ret_addr, ret_data, ret_cntrl, ret_z  out  1/AW/DW/CW/ZW  retired entry fields
- ret_fwd  out  1  retired load was forwarded
- empty, full  out  1  queue status
- count  out  IDW+1  occupancy

## Operation
- Per-entry state: FREE, WAIT (not yet issued), ISSUED, DONE. Per-entry fields: rw, addr, data, cntrl, z, fwd.
- Pointers: head (oldest), tail (next free), iss (next to issue). All are IDW bits and wrap modulo DEPTH. count disambiguates full from empty.
- Enqueue:
  - Accepted when enq_valid && !full; the entry is written at tail and tail advances.
  - Enqueue while full is dropped. No state changes.
  - Store: entry enters WAIT.
  - Load: word-address compare (addr[AW-1:2]) against all non-FREE older store entries.
    - On a hit, the youngest matching store's data is copied, fwd=1, and the entry enters DONE.
    - On a miss, the entry enters WAIT.
- Issue:
  - mem_* are combinational from the entry at iss; mem_valid = (state[iss]==WAIT).
  - If state[iss]==DONE (forwarded) and iss≠tail, iss advances with no request.
  - Request is accepted at an edge with mem_valid && !mem_stall: entry goes to ISSUED and iss advances.
  - At most one issue or one skip per cycle.
- Response: mem_resp_valid with an entry in ISSUED moves it to DONE; load data is latched, store data is kept. A response to a non-ISSUED entry is ignored.
- Retire:
  - If state[head]==DONE, ret_* are registered from that entry with ret_valid=1, the entry goes to FREE, and head advances.
  - At most one retire per cycle. Otherwise ret_valid=0 and the other ret_* hold their values.
- count += accepted enqueue − retire. empty=(count==0), full=(count==DEPTH), both registered.

## Timing
- Reset: all entries FREE, pointers and count 0, empty=1, full=0, ret_* 0, mem_valid 0.
- Reset asserted mid-operation discards every entry. In-flight responses arriving after reset are ignored.
- Enqueue accepted at edge E:
  - Non-forwarded entry can appear on mem_valid in cycle E+1 if iss points at it.
  - Forwarded entry retires with ret_valid in cycle E+1 if it is at head.
- Response at edge R: head retire visible in cycle R+1 at earliest. Response and retire of the same entry never occur on the same edge.
- Simultaneous enqueue and retire when full: enqueue is still refused, because full is registered.
- Simultaneous enqueue and retire when count==1: count stays 1 and empty stays 0.
- A store retiring on the same edge as a matching load's enqueue still forwards, since the compare uses pre-edge state.
- mem_stall must not depend combinationally on mem_valid.

## Structure
- Package ldst_queue_pkg holds the entry-state enum and the default width constants.
- Sub-module ldst_fwd_match: combinational youngest-older-store priority search, with age taken relative to head. It returns hit and index.

## Test plan
- Reset, then enqueue load addr 0x8, memory returns 0x1234 two cycles later -> ret_valid, ret_data 0x1234, ret_fwd 0, empty back to 1.
- Store 0x10←0xAA then load 0x10 back-to-back -> only the store is issued (mem_id 0); load retires after it with data 0xAA and ret_fwd 1.
- Three loads, IDs 0,1,2, responses in order 2,0,1 -> retires in order 0,1,2, each with its own data.
- Enqueue 16 with mem_stall held high -> full=1, enq_ready=0, and the 17th enqueue is dropped. Release stall and complete all -> 16 in-order retires, and pointers wrap to 0.
- Stores 0x20←1 then 0x20←2, then load 0x20 -> forwarded data 2.
- rst asserted with 5 entries in flight, followed by a response -> no ret_valid, count 0, empty 1.
